// File: rtl/score_pkg.sv
// Shared types and helpers for the floor counter: FSM state codes, 7-segment decode
// and decimal-to-BCD conversion of the win target.
package score_pkg;

  localparam int unsigned TargetDefault = 100;
  localparam logic [3:0]  BcdBlank      = 4'hF;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StPaused = 3'd2,
    StOver   = 3'd3,
    StWin    = 3'd4
  } state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left dark here and applied by the caller.
  function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  function automatic logic [11:0] to_bcd(input int unsigned val);
    logic [11:0] bcd;
    bcd[11:8] = 4'((val / 100) % 10);
    bcd[7:4]  = 4'((val / 10) % 10);
    bcd[3:0]  = 4'(val % 10);
    return bcd;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 3-digit common-anode display driver: scan timer, leading-zero blanking,
// decode and registered anode/segment outputs.
module seg_scan
  import score_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [3:0] bcd_hund,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  input  logic       dp_ones,
  input  logic       dp_all,
  output logic [2:0] an_n,
  output logic [7:0] seg_n
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]      digit_q, digit_nxt;
  logic [2:0]      an_n_q, an_nxt;
  logic [7:0]      seg_n_q, seg_nxt;
  logic            advance;
  logic [3:0]      digit_val;
  logic            digit_dp;
  logic            hund_blank, tens_blank;

  assign advance    = (scan_cnt_q == CntMax);
  assign scan_cnt_d = advance ? '0 : scan_cnt_q + 1'b1;
  assign digit_nxt  = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
  assign hund_blank = (bcd_hund == 4'd0);
  assign tens_blank = hund_blank && (bcd_tens == 4'd0);

  // Content is decoded for the digit about to be lit, so anode and segments switch together.
  always_comb begin
    digit_val = bcd_ones;
    digit_dp  = dp_ones | dp_all;
    an_nxt    = 3'b110;
    unique case (digit_nxt)
      2'd0: begin
        digit_val = bcd_ones;
        digit_dp  = dp_ones | dp_all;
        an_nxt    = 3'b110;
      end
      2'd1: begin
        digit_val = tens_blank ? BcdBlank : bcd_tens;
        digit_dp  = dp_all;
        an_nxt    = 3'b101;
      end
      default: begin
        digit_val = hund_blank ? BcdBlank : bcd_hund;
        digit_dp  = dp_all;
        an_nxt    = 3'b011;
      end
    endcase
    seg_nxt = seg_decode(digit_val);
    if (digit_dp) seg_nxt[7] = 1'b0;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= 2'd0;
      an_n_q     <= 3'b110;
      seg_n_q    <= 8'hC0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      if (advance) begin
        digit_q <= digit_nxt;
        an_n_q  <= an_nxt;
        seg_n_q <= seg_nxt;
      end
    end
  end

  assign an_n  = an_n_q;
  assign seg_n = seg_n_q;

endmodule

// File: rtl/score_keeper.sv
// Floor counter for the 100-floor game: synchronises the slow score clock, counts its
// rising edges in BCD under the game FSM and drives the 3-digit display.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned TARGET   = TargetDefault,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clk_score,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       score_tick,
  output logic [2:0] state_o,
  output logic       win,
  output logic [2:0] an_n,
  output logic [7:0] seg_n
);

  localparam logic [11:0] TargetBcd = to_bcd(TARGET);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       score_edge;

  state_e      state_q, state_d;
  logic [11:0] count_q, count_d, count_inc;
  logic        tick_d, tick_q;
  logic        win_q;

  // After reset, edges are only armed once s2 has held a real low sample, so a score
  // clock that is already high at reset release is never counted.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= clk_score;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~s2_q);
    end
  end

  assign score_edge = armed_q & s2_q & ~s3_q;

  always_comb begin
    count_inc = count_q;
    if (count_q[3:0] == 4'd9) begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] == 4'd9) begin
        count_inc[7:4]  = 4'd0;
        count_inc[11:8] = count_q[11:8] + 4'd1;
      end else begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end
    end else begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!game_over && start) state_d = StRun;
      end
      StRun: begin
        if (game_over) begin
          state_d = StOver;
        end else if (pause) begin
          state_d = StPaused;
        end else if (score_edge) begin
          count_d = count_inc;
          tick_d  = 1'b1;
          if (count_inc == TargetBcd) state_d = StWin;
        end
      end
      StPaused: begin
        if (game_over)   state_d = StOver;
        else if (!pause) state_d = StRun;
      end
      StOver, StWin: begin
        if (!game_over && start) begin
          state_d = StRun;
          count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      tick_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      win_q   <= (state_d == StWin);
    end
  end

  assign bcd_hund   = count_q[11:8];
  assign bcd_tens   = count_q[7:4];
  assign bcd_ones   = count_q[3:0];
  assign score_tick = tick_q;
  assign state_o    = state_q;
  assign win        = win_q;

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .bcd_hund (count_q[11:8]),
    .bcd_tens (count_q[7:4]),
    .bcd_ones (count_q[3:0]),
    .dp_ones  (state_q == StPaused),
    .dp_all   (state_q == StWin),
    .an_n     (an_n),
    .seg_n    (seg_n)
  );

endmodule
